// File: rtl/supervise_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : supervise_pkg                                               |
// | Brief   : Shared FSM state encoding and default activation level.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package supervise_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARGUMENT  = 3'd1,
      ST_RESULT    = 3'd2,
      ST_ERROR     = 3'd3,
      ST_PROPAGATE = 3'd4,
      ST_REPORT    = 3'd5
   } state_e;

   localparam logic [15:0] ONE_DEFAULT = 16'h00ff;

endpackage
`default_nettype wire

// File: rtl/supervise_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : supervise_if                                                |
// | Brief   : Six valid/ready channels between supervisor and environment.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface supervise_if #(
   parameter int N = 2,
   parameter int W = 8,
   parameter int R = 16
);
   logic                    sample_valid;
   logic                    sample_ready;
   logic [N*W+R-1:0]        sample_data;
   logic                    argument_valid;
   logic                    argument_ready;
   logic [N-1:0][W-1:0]     argument_data;
   logic                    result_valid;
   logic                    result_ready;
   logic [R-1:0]            result_data;
   logic                    error_valid;
   logic                    error_ready;
   logic [R-1:0]            error_data;
   logic                    propagate_valid;
   logic                    propagate_ready;
   logic [N-1:0][R-1:0]     propagate_data;
   logic                    outcome_valid;
   logic                    outcome_ready;
   logic [2*R-1:0]          outcome_data;

   // Environment side: supplies samples, results and gradients, consumes the rest
   modport master (
      output sample_valid, sample_data, input sample_ready,
      input  argument_valid, argument_data, output argument_ready,
      output result_valid, result_data, input result_ready,
      input  error_valid, error_data, output error_ready,
      output propagate_valid, propagate_data, input propagate_ready,
      input  outcome_valid, outcome_data, output outcome_ready
   );

   modport slave (
      input  sample_valid, sample_data, output sample_ready,
      output argument_valid, argument_data, input argument_ready,
      input  result_valid, result_data, output result_ready,
      output error_valid, error_data, input error_ready,
      input  propagate_valid, propagate_data, output propagate_ready,
      output outcome_valid, outcome_data, input outcome_ready
   );
endinterface
`default_nettype wire

// File: rtl/supervise_threshold.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : threshold                                                   |
// | Brief   : Step activation and saturated Q8.8 error (target - act).    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module threshold
   import supervise_pkg::*;
#(
   parameter int             R   = 16,
   parameter logic [R-1:0]   ONE = R'(ONE_DEFAULT)
) (
   input  wire logic [R-1:0] result,
   input  wire logic [R-1:0] target,
   output logic      [R-1:0] act,
   output logic      [R-1:0] err
);
   logic [R:0] diff;

   always_comb begin
      act  = result[R-1] ? '0 : ONE;
      diff = {target[R-1], target} - {act[R-1], act};
      // Top two bits disagree only when the difference left the R-bit range
      if (diff[R] != diff[R-1]) begin
         err = diff[R] ? {1'b1, {(R-1){1'b0}}} : {1'b0, {(R-1){1'b1}}};
      end else begin
         err = diff[R-1:0];
      end
   end
endmodule
`default_nettype wire

// File: rtl/supervise.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : supervise                                                   |
// | Brief   : Single-transaction supervised-training sequencer.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module supervise
   import supervise_pkg::*;
#(
   parameter int           N   = 2,
   parameter int           W   = 8,
   parameter int           R   = 16,
   parameter logic [R-1:0] ONE = R'(ONE_DEFAULT)
) (
   input  wire logic  clock,
   input  wire logic  reset,
   input  wire logic  train,
   input  wire logic  clear,
   supervise_if.slave bus,
   output logic [15:0] mistakes
);
   state_e           state_q, state_d;
   logic             run_q, run_d;
   logic [N*W-1:0]   arg_q, arg_d;
   logic [R-1:0]     target_q, target_d;
   logic             train_q, train_d;
   logic [R-1:0]     act_q, act_d;
   logic [R-1:0]     err_q, err_d;
   logic [15:0]      mistakes_q, mistakes_d;
   logic [R-1:0]     act_w, err_w;

   threshold #(.R(R), .ONE(ONE)) u_threshold (
      .result (bus.result_data),
      .target (target_q),
      .act    (act_w),
      .err    (err_w)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         run_q      <= 1'b0;
         arg_q      <= '0;
         target_q   <= '0;
         train_q    <= 1'b0;
         act_q      <= '0;
         err_q      <= '0;
         mistakes_q <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         arg_q      <= arg_d;
         target_q   <= target_d;
         train_q    <= train_d;
         act_q      <= act_d;
         err_q      <= err_d;
         mistakes_q <= mistakes_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      run_d      = 1'b1;
      arg_d      = arg_q;
      target_d   = target_q;
      train_d    = train_q;
      act_d      = act_q;
      err_d      = err_q;
      mistakes_d = mistakes_q;
      case (state_q)
         ST_IDLE: begin
            if (run_q && bus.sample_valid) begin
               arg_d    = bus.sample_data[N*W-1:0];
               target_d = bus.sample_data[N*W +: R];
               train_d  = train;
               state_d  = ST_ARGUMENT;
            end
         end
         ST_ARGUMENT: begin
            if (bus.argument_ready) state_d = ST_RESULT;
         end
         ST_RESULT: begin
            if (bus.result_valid) begin
               act_d   = act_w;
               err_d   = err_w;
               state_d = train_q ? ST_ERROR : ST_REPORT;
               if (err_w != '0 && mistakes_q != 16'hffff) mistakes_d = mistakes_q + 16'd1;
            end
         end
         ST_ERROR: begin
            if (bus.error_ready) state_d = ST_PROPAGATE;
         end
         ST_PROPAGATE: begin
            if (bus.propagate_valid) state_d = ST_REPORT;
         end
         ST_REPORT: begin
            if (bus.outcome_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear) mistakes_d = '0;
   end

   // run_q holds sample_ready low until the first edge after reset release
   assign bus.sample_ready    = run_q && (state_q == ST_IDLE);
   assign bus.argument_valid  = (state_q == ST_ARGUMENT);
   assign bus.argument_data   = arg_q;
   assign bus.result_ready    = (state_q == ST_RESULT);
   assign bus.error_valid     = (state_q == ST_ERROR);
   assign bus.error_data      = err_q;
   assign bus.propagate_ready = (state_q == ST_PROPAGATE);
   assign bus.outcome_valid   = (state_q == ST_REPORT);
   assign bus.outcome_data    = {act_q, err_q};
   assign mistakes            = mistakes_q;
endmodule
`default_nettype wire

// File: tb/tb_supervise.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_supervise                                                |
// | Brief   : Randomised scoreboard bench with a perceptron partner model.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_supervise;
   localparam int N = 2;
   localparam int W = 8;
   localparam int R = 16;

   typedef struct packed {
      logic [R-1:0]   target;
      logic [N*W-1:0] arg;
      logic           train;
   } smp_t;

   typedef struct packed {
      logic [2*R-1:0] outc;
      logic [15:0]    mist;
   } out_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        train = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] mistakes;

   supervise_if #(.N(N), .W(W), .R(R)) bus ();

   supervise #(.N(N), .W(W), .R(R)) dut (
      .clock    (clock),
      .reset    (reset),
      .train    (train),
      .clear    (clear),
      .bus      (bus),
      .mistakes (mistakes)
   );

   always #5 clock = ~clock;

   smp_t           sq[$];
   logic [R-1:0]   rq[$];
   logic [N*W-1:0] q_arg[$];
   logic [R-1:0]   q_err[$];
   out_t           q_out[$];

   int  checks = 0;
   int  passed = 0;
   int  mist_model = 0;
   bit  env_on = 1'b0;
   bit  prop_hold = 1'b0;
   bit  clear_hold = 1'b0;
   bit  hs_sample, hs_arg, hs_result, hs_error, hs_prop, hs_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic unexpected(input string name);
      checks++;
      $display("FAIL %s: handshake seen with nothing expected (got 1 transfer, required 0)", name);
   endtask

   // Reference rule: step activation, then target - act clamped to signed 16 bits
   function automatic logic [2*R-1:0] ref_outcome(input logic [R-1:0] res, input logic [R-1:0] tgt);
      int a;
      int t;
      int e;
      a = ($signed(res) < 0) ? 0 : 255;
      t = $signed(tgt);
      e = t - a;
      if (e > 32767) e = 32767;
      if (e < -32768) e = -32768;
      return {16'(a), 16'(e)};
   endfunction

   task automatic issue_exp(input logic [R-1:0] tgt, input logic [N*W-1:0] arg,
                            input logic [R-1:0] res, input bit tr,
                            input logic [R-1:0] e_act, input logic [R-1:0] e_err);
      out_t o;
      sq.push_back('{target: tgt, arg: arg, train: tr});
      rq.push_back(res);
      q_arg.push_back(arg);
      if (tr) q_err.push_back(e_err);
      if (clear_hold) mist_model = 0;
      else if (e_err != '0 && mist_model < 65535) mist_model++;
      o.outc = {e_act, e_err};
      o.mist = 16'(mist_model);
      q_out.push_back(o);
   endtask

   task automatic issue_ref(input logic [R-1:0] tgt, input logic [N*W-1:0] arg,
                            input logic [R-1:0] res, input bit tr);
      logic [2*R-1:0] o;
      o = ref_outcome(res, tgt);
      issue_exp(tgt, arg, res, tr, o[2*R-1:R], o[R-1:0]);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((sq.size() != 0 || q_out.size() != 0) && n < budget) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (sq.size() == 0 && q_out.size() == 0) passed++;
      else $display("FAIL %s: %0d outcomes outstanding after %0d cycles, required 0", name, q_out.size(), budget);
   endtask

   // Environment partners: drive inputs shortly after each rising edge
   initial begin : driver
      forever begin
         @(posedge clock);
         #1;
         if (env_on) begin
            if (hs_sample) begin
               bus.sample_valid = 1'b0;
               if (sq.size() > 0) sq.delete(0);
            end
            if (!bus.sample_valid && sq.size() > 0 && $urandom_range(0, 3) != 0) begin
               bus.sample_valid = 1'b1;
               bus.sample_data  = {sq[0].target, sq[0].arg};
               train            = sq[0].train;
            end else if (!bus.sample_valid) begin
               train = 1'($urandom_range(0, 1));
            end
            bus.argument_ready = ($urandom_range(0, 2) != 0);
            if (hs_result) begin
               bus.result_valid = 1'b0;
               if (rq.size() > 0) rq.delete(0);
            end
            if (!bus.result_valid && rq.size() > 0 && $urandom_range(0, 3) != 0) begin
               bus.result_valid = 1'b1;
               bus.result_data  = rq[0];
            end
            bus.error_ready = ($urandom_range(0, 2) != 0);
            if (hs_prop) bus.propagate_valid = 1'b0;
            if (!bus.propagate_valid && !prop_hold && $urandom_range(0, 2) != 0) begin
               bus.propagate_valid = 1'b1;
               bus.propagate_data  = 32'($urandom);
            end
            bus.outcome_ready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   // Monitor: sample at the falling edge, check holds and pop the scoreboard
   initial begin : monitor
      bit             prev_av, prev_ahs, prev_ev, prev_ehs, prev_ov, prev_ohs;
      logic [N*W-1:0] prev_ad;
      logic [R-1:0]   prev_ed;
      logic [2*R-1:0] prev_od;
      prev_av = 0; prev_ahs = 0; prev_ev = 0; prev_ehs = 0; prev_ov = 0; prev_ohs = 0;
      prev_ad = '0; prev_ed = '0; prev_od = '0;
      forever begin
         @(negedge clock);
         hs_sample = bus.sample_valid && bus.sample_ready;
         hs_arg    = bus.argument_valid && bus.argument_ready;
         hs_result = bus.result_valid && bus.result_ready;
         hs_error  = bus.error_valid && bus.error_ready;
         hs_prop   = bus.propagate_valid && bus.propagate_ready;
         hs_out    = bus.outcome_valid && bus.outcome_ready;
         if (reset) begin
            if (prev_av && !prev_ahs)
               check("argument_hold", {bus.argument_valid, bus.argument_data}, {1'b1, prev_ad});
            if (prev_ev && !prev_ehs)
               check("error_hold", {bus.error_valid, bus.error_data}, {1'b1, prev_ed});
            if (prev_ov && !prev_ohs)
               check("outcome_hold", {bus.outcome_valid, bus.outcome_data}, {1'b1, prev_od});
            if (hs_arg) begin
               if (q_arg.size() == 0) unexpected("argument_extra");
               else begin
                  check("argument_data", bus.argument_data, q_arg[0]);
                  q_arg.delete(0);
               end
            end
            if (hs_error) begin
               if (q_err.size() == 0) unexpected("error_extra");
               else begin
                  check("error_data", bus.error_data, q_err[0]);
                  q_err.delete(0);
               end
            end
            if (hs_out) begin
               if (q_out.size() == 0) unexpected("outcome_extra");
               else begin
                  check("outcome_data", bus.outcome_data, q_out[0].outc);
                  check("mistakes", mistakes, q_out[0].mist);
                  q_out.delete(0);
               end
            end
         end
         prev_av = bus.argument_valid; prev_ahs = hs_arg; prev_ad = bus.argument_data;
         prev_ev = bus.error_valid;    prev_ehs = hs_error; prev_ed = bus.error_data;
         prev_ov = bus.outcome_valid;  prev_ohs = hs_out;  prev_od = bus.outcome_data;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check_idle_reset(input string name);
      check({name, "_ctrl"}, {bus.sample_ready, bus.argument_valid, bus.result_ready,
                              bus.error_valid, bus.propagate_ready, bus.outcome_valid}, 6'b0);
      check({name, "_mistakes"}, mistakes, 16'h0000);
   endtask

   initial begin : main
      int             n;
      int             wt0, wt1, bias, e, s, x0, x1, mist_before;
      bit             tr;
      logic [R-1:0]   tgt, res;
      logic [2*R-1:0] o;

      bus.sample_valid = 1'b0; bus.sample_data = '0;
      bus.argument_ready = 1'b0;
      bus.result_valid = 1'b0; bus.result_data = '0;
      bus.error_ready = 1'b0;
      bus.propagate_valid = 1'b0; bus.propagate_data = '0;
      bus.outcome_ready = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check_idle_reset("reset");
      check("reset_data", {bus.argument_data, bus.outcome_data, bus.error_data}, 64'h0);
      @(negedge clock);
      reset = 1'b1;
      check("ready_before_edge", bus.sample_ready, 1'b0);
      @(posedge clock);
      #1;
      check("ready_after_release", bus.sample_ready, 1'b1);
      env_on = 1'b1;

      issue_exp(16'h00ff, 16'hffff, 16'h0100, 1'b0, 16'h00ff, 16'h0000);
      drain("no_train", 200);
      issue_exp(16'h0000, 16'h1234, 16'h0001, 1'b1, 16'h00ff, 16'hff01);
      drain("train_one", 200);
      issue_exp(16'h8000, 16'h0a0b, 16'h0000, 1'b0, 16'h00ff, 16'h8000);
      drain("sat_low", 200);
      issue_exp(16'h7fff, 16'h0c0d, 16'hffff, 1'b1, 16'h0000, 16'h7fff);
      drain("sat_high", 200);
      check("mistakes_count", mistakes, 16'd3);

      @(posedge clock); #1; clear = 1'b1;
      @(posedge clock); #1; clear = 1'b0;
      check("clear_pulse", mistakes, 16'h0000);
      mist_model = 0;

      // clear held across a mistaken transaction wins over the increment
      clear = 1'b1; clear_hold = 1'b1;
      issue_exp(16'h0000, 16'h5555, 16'h0001, 1'b0, 16'h00ff, 16'hff01);
      drain("clear_override", 200);
      clear = 1'b0; clear_hold = 1'b0;

      for (int i = 0; i < 100; i++) begin
         case ($urandom_range(0, 3))
            0:       tgt = 16'h00ff;
            1:       tgt = 16'h0000;
            2:       tgt = 16'($urandom);
            default: tgt = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
         endcase
         issue_ref(tgt, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
      drain("random_100", 8000);

      prop_hold = 1'b1;
      issue_ref(16'h0000, 16'h0101, 16'h0001, 1'b1);
      n = 0;
      while (!bus.propagate_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("reach_propagate", bus.propagate_ready, 1'b1);
      @(posedge clock);
      #2;
      reset = 1'b0;
      env_on = 1'b0;
      bus.sample_valid = 1'b0;
      bus.result_valid = 1'b0;
      bus.propagate_valid = 1'b0;
      prop_hold = 1'b0;
      sq.delete(); rq.delete(); q_arg.delete(); q_err.delete(); q_out.delete();
      mist_model = 0;
      #1;
      check_idle_reset("mid_reset");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("ready_after_mid_reset", bus.sample_ready, 1'b1);
      env_on = 1'b1;
      issue_ref(16'h00ff, 16'h0202, 16'h0003, 1'b1);
      drain("after_reset", 200);

      // Perceptron partner learning AND; weights move by err * x each trained sample
      wt0 = 0; wt1 = 0; bias = 0;
      mist_before = 0;
      for (int ep = 0; ep < 26; ep++) begin
         tr = (ep < 25);
         if (!tr) mist_before = mist_model;
         for (int k = 0; k < 4; k++) begin
            x0  = (k >> 1) & 1;
            x1  = k & 1;
            tgt = (x0 == 1 && x1 == 1) ? 16'h00ff : 16'h0000;
            s   = wt0 * x0 + wt1 * x1 + bias;
            res = 16'(s);
            if (tr) begin
               o = ref_outcome(res, tgt);
               issue_exp(tgt, {8'(x1), 8'(x0)}, res, 1'b1, o[2*R-1:R], o[R-1:0]);
               e = $signed(o[R-1:0]);
               wt0 += e * x0;
               wt1 += e * x1;
               bias += e;
            end else begin
               issue_exp(tgt, {8'(x1), 8'(x0)}, res, 1'b0, tgt, 16'h0000);
            end
            drain("and_step", 200);
         end
      end
      check("and_final_mistakes", mistakes, 16'(mist_before));

      repeat (5) @(posedge clock);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
`default_nettype wire
